// File: rtl/booth_mul_sched.sv
// rtl/booth_mul_sched.sv - round-robin scheduler sharing one sequential Booth multiplier
module booth_mul_sched #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [6*N-1:0]   op_a,
  input  logic [6*N-1:0]   op_b,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic             done,
  output logic [IDW-1:0]   done_id,
  output logic [11:0]      result,
  output logic             err,
  output logic [5:0]       mul_a,
  output logic [5:0]       mul_b,
  output logic             mul_load,
  input  logic [11:0]      mul_product,
  input  logic             mul_ready
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_e;

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  win_q, win_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IDW-1:0]  done_id_q, done_id_d;
  logic [11:0]     result_q, result_d;
  logic            err_q, err_d;
  logic [5:0]      mul_a_q, mul_a_d;
  logic [5:0]      mul_b_q, mul_b_d;
  logic            mul_load_q, mul_load_d;

  logic            found;
  logic [IDW-1:0]  pick;
  logic [5:0]      pick_a, pick_b;
  int              idx;

  // Round-robin pick: first active requester at or above the rr pointer, wrapping
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    pick_a = '0;
    pick_b = '0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        pick   = IDW'(idx);
        pick_a = op_a[6*idx +: 6];
        pick_b = op_b[6*idx +: 6];
      end
    end
  end

  // Next-state and registered-output logic; ready is only looked at in WAIT
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    result_d   = result_q;
    err_d      = 1'b0;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_load_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[pick] = 1'b1;
          win_d      = pick;
          mul_a_d    = pick_a;
          mul_b_d    = pick_b;
          mul_load_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_ready || (cnt_q == CNT_LAST)) begin
          result_d  = mul_ready ? mul_product : 12'h000;
          err_d     = ~mul_ready;
          done_d    = 1'b1;
          done_id_d = win_q;
          gnt_d     = '0;
          busy_d    = 1'b0;
          rr_d      = (win_q == IDW'(N - 1)) ? '0 : win_q + 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      result_q   <= result_d;
      err_q      <= err_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_load_q <= mul_load_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign done_id  = done_id_q;
  assign result   = result_q;
  assign err      = err_q;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign mul_load = mul_load_q;

endmodule
